axis_pattern_checker: RTL

//  AXI4-Stream sink that checks packets from the traffic generator.
//  It verifies the sequence number, the length field, TKEEP framing and the byte payload pattern.
//  It counts received packets and errored packets.

---
 rtl/axis_pattern_checker.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/axis_pattern_checker.sv
// AXI4-Stream sink that validates generator packets: sequence number, length field,
// TKEEP framing and the incrementing byte payload, and counts good and errored packets.
module axis_pattern_checker #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 64,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                                AXIS_ACLK,
    input  logic                                AXIS_ARESETN,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TKEEP,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                                S_AXIS_TVALID,
    output logic                                S_AXIS_TREADY,
    input  logic                                S_AXIS_TLAST,
    input  logic                                count_reset,
    output logic [31:0]                         rx_count,
    output logic [31:0]                         err_count,
    output logic [31:0]                         seq_expected
);

    localparam int unsigned KW = C_S_AXIS_DATA_WIDTH / 8;

    typedef enum logic {StHeader, StPayload} state_e;

    state_e        state_q, state_d;
    logic          tready_q, tready_d;
    logic [15:0]   offset_q, offset_d;
    logic [16:0]   bytes_q, bytes_d;
    logic [15:0]   len_q, len_d;
    logic          err_q, err_d;
    logic [31:0]   rx_count_q, rx_count_d;
    logic [31:0]   err_count_q, err_count_d;
    logic [31:0]   seq_exp_q, seq_exp_d;

    logic          fire;
    logic          hdr;
    logic [31:0]   rx_seq;
    logic [15:0]   hdr_len;
    logic [15:0]   cur_len;
    logic [16:0]   kept_cnt;
    logic [16:0]   total;
    logic          data_err;
    logic [KW:0]   keep_inc;
    logic          keep_contig;
    logic          beat_err;
    logic          unused_tuser;

    assign unused_tuser = ^S_AXIS_TUSER;

    always_comb begin
        fire     = S_AXIS_TVALID && tready_q;
        hdr      = (state_q == StHeader);
        rx_seq   = S_AXIS_TDATA[31:0];
        hdr_len  = S_AXIS_TDATA[47:32];
        cur_len  = hdr ? hdr_len : len_q;

        kept_cnt = '0;
        data_err = 1'b0;
        for (int unsigned l = 0; l < KW; l++) begin
            kept_cnt = kept_cnt + 17'(S_AXIS_TKEEP[l]);
            // Header lanes 0..5 carry seq/length; everything else is the offset pattern.
            if (S_AXIS_TKEEP[l] && (!hdr || l >= 6) &&
                (S_AXIS_TDATA[8*l +: 8] != (offset_q[7:0] + 8'(l)))) begin
                data_err = 1'b1;
            end
        end
        total = (hdr ? 17'd0 : bytes_q) + kept_cnt;

        // Contiguous-from-lane-0 mask has the form 0..01..1: mask & (mask+1) == 0.
        keep_inc    = {1'b0, S_AXIS_TKEEP} + {{KW{1'b0}}, 1'b1};
        keep_contig = (|S_AXIS_TKEEP) && !(|({1'b0, S_AXIS_TKEEP} & keep_inc));

        beat_err = data_err || total[16];
        if (hdr && (rx_seq != seq_exp_q)) beat_err = 1'b1;
        if (hdr && (hdr_len < 16'd6))     beat_err = 1'b1;
        if (!S_AXIS_TLAST && (S_AXIS_TKEEP != {KW{1'b1}})) beat_err = 1'b1;
        if (S_AXIS_TLAST && !keep_contig) beat_err = 1'b1;
        if (S_AXIS_TLAST && (total != {1'b0, cur_len})) beat_err = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        tready_d    = 1'b1;
        offset_d    = offset_q;
        bytes_d     = bytes_q;
        len_d       = len_q;
        err_d       = err_q;
        rx_count_d  = rx_count_q;
        err_count_d = err_count_q;
        seq_exp_d   = count_reset ? 32'd0 : seq_exp_q;

        if (fire) begin
            if (hdr) begin
                len_d     = hdr_len;
                seq_exp_d = rx_seq + 32'd1;
            end
            if (S_AXIS_TLAST) begin
                state_d  = StHeader;
                offset_d = '0;
                bytes_d  = '0;
                err_d    = 1'b0;
                if (!count_reset) begin
                    rx_count_d = rx_count_q + 32'd1;
                    if (err_q || beat_err) err_count_d = err_count_q + 32'd1;
                end
            end else begin
                state_d  = StPayload;
                offset_d = offset_q + 16'(KW);
                bytes_d  = total;
                err_d    = err_q || beat_err;
            end
        end

        if (count_reset) begin
            rx_count_d  = '0;
            err_count_d = '0;
        end
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_q     <= StHeader;
            tready_q    <= 1'b0;
            offset_q    <= '0;
            bytes_q     <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            rx_count_q  <= '0;
            err_count_q <= '0;
            seq_exp_q   <= '0;
        end else begin
            state_q     <= state_d;
            tready_q    <= tready_d;
            offset_q    <= offset_d;
            bytes_q     <= bytes_d;
            len_q       <= len_d;
            err_q       <= err_d;
            rx_count_q  <= rx_count_d;
            err_count_q <= err_count_d;
            seq_exp_q   <= seq_exp_d;
        end
    end

    assign S_AXIS_TREADY = tready_q;
    assign rx_count      = rx_count_q;
    assign err_count     = err_count_q;
    assign seq_expected  = seq_exp_q;

endmodule
